// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: merges the stall-free multiplier stream with the ALU/memory
// stream onto one register-bank write port, parking colliding ALU results in a FIFO.
module cpu_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mul_valid,
  input  logic [REG_ID_WIDTH-1:0] mul_rd_id,
  input  logic [DATA_WIDTH-1:0]   mul_data,
  input  logic                    alu_valid,
  input  logic [REG_ID_WIDTH-1:0] alu_rd_id,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  output logic                    wb_stall,
  output logic                    rf_we,
  output logic [REG_ID_WIDTH-1:0] rf_rd_id,
  output logic [DATA_WIDTH-1:0]   rf_data,
  input  logic [REG_ID_WIDTH-1:0] hdu_query_id,
  output logic                    hdu_query_hit,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(FIFO_DEPTH - 1);

  logic [REG_ID_WIDTH-1:0] rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        count;

  logic                    pop, bypass, push, push_ok, full;
  logic                    wr_en_d;
  logic [REG_ID_WIDTH-1:0] wr_rd_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
  logic [CNT_W-1:0]        count_d;
  logic [PTR_W-1:0]        idx;

  // Handshake: the ALU side has no ready; it must hold off alu_valid while
  // wb_stall is high. wb_stall depends only on registered count, leaving one
  // spare slot for the beat already in flight when it rises.
  assign wb_stall = (count >= STALL_C);
  assign full     = (count == DEPTH_C);

  always_comb begin
    pop       = 1'b0;
    bypass    = 1'b0;
    push      = 1'b0;
    wr_en_d   = 1'b0;
    wr_rd_d   = mul_rd_id;
    wr_data_d = mul_data;
    if (mul_valid) begin
      wr_en_d = 1'b1;
      push    = alu_valid;
    end else if (count != '0) begin
      pop       = 1'b1;
      wr_en_d   = 1'b1;
      wr_rd_d   = rd_q[rd_ptr];
      wr_data_d = data_q[rd_ptr];
      push      = alu_valid;
    end else if (alu_valid) begin
      bypass    = 1'b1;
      wr_en_d   = 1'b1;
      wr_rd_d   = alu_rd_id;
      wr_data_d = alu_data;
    end
    push_ok = push && (!full || pop);
    count_d = count;
    case ({push_ok, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Entry popped this cycle is already on its way to the port, so it is skipped.
  always_comb begin
    hdu_query_hit = 1'b0;
    idx           = rd_ptr;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && !(i == 0 && pop) && (rd_q[idx] == hdu_query_id))
        hdu_query_hit = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rf_we    <= 1'b0;
      rf_rd_id <= '0;
      rf_data  <= '0;
    end else begin
      count <= count_d;
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && !push_ok)
        overflow <= 1'b1;
      rf_we <= wr_en_d;
      if (wr_en_d) begin
        rf_rd_id <= wr_rd_d;
        rf_data  <= wr_data_d;
      end
    end
  end

  // Storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      rd_q[wr_ptr]   <= alu_rd_id;
      data_q[wr_ptr] <= alu_data;
    end
  end

  logic unused_bypass;
  assign unused_bypass = bypass;

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Bench for cpu_wb_arbiter: directed scenarios then random traffic, checked
// against a queue-based model of the arbitration rules.
module tb_cpu_wb_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mul_valid = 1'b0;
  logic [RW-1:0] mul_rd_id = '0;
  logic [DW-1:0] mul_data = '0;
  logic          alu_valid = 1'b0;
  logic [RW-1:0] alu_rd_id = '0;
  logic [DW-1:0] alu_data = '0;
  logic          wb_stall;
  logic          rf_we;
  logic [RW-1:0] rf_rd_id;
  logic [DW-1:0] rf_data;
  logic [RW-1:0] hdu_query_id = '0;
  logic          hdu_query_hit;
  logic          overflow;

  cpu_wb_arbiter #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .mul_valid(mul_valid), .mul_rd_id(mul_rd_id), .mul_data(mul_data),
    .alu_valid(alu_valid), .alu_rd_id(alu_rd_id), .alu_data(alu_data),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_rd_id(rf_rd_id), .rf_data(rf_data),
    .hdu_query_id(hdu_query_id), .hdu_query_hit(hdu_query_hit), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Model state: queued ALU results {rd, data} in arrival order.
  logic [RW+DW-1:0] exp_q[$];
  logic             exp_we, exp_ovf;
  logic [RW-1:0]    exp_rd;
  logic [DW-1:0]    exp_data;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic mv, input logic [RW-1:0] mrd, input logic [DW-1:0] md,
                      input logic av, input logic [RW-1:0] ard, input logic [DW-1:0] ad,
                      input logic [RW-1:0] qid);
    logic ex_stall, ex_hit, popping;
    logic [RW+DW-1:0] e;
    @(negedge clock);
    mul_valid = mv; mul_rd_id = mrd; mul_data = md;
    alu_valid = av; alu_rd_id = ard; alu_data = ad;
    hdu_query_id = qid;
    #1;
    ex_stall = (exp_q.size() >= DEPTH - 1);
    popping  = !mv && exp_q.size() > 0;
    ex_hit   = 1'b0;
    for (int i = (popping ? 1 : 0); i < exp_q.size(); i++)
      if (exp_q[i][RW+DW-1:DW] == qid) ex_hit = 1'b1;
    check("wb_stall", wb_stall, ex_stall);
    check("hdu_query_hit", hdu_query_hit, ex_hit);
    exp_we = 1'b0;
    if (mv) begin
      exp_we = 1'b1; exp_rd = mrd; exp_data = md;
    end else if (popping) begin
      e = exp_q.pop_front();
      exp_we = 1'b1; exp_rd = e[RW+DW-1:DW]; exp_data = e[DW-1:0];
    end else if (av) begin
      exp_we = 1'b1; exp_rd = ard; exp_data = ad;
    end
    if (av && (mv || popping)) begin
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({ard, ad});
    end
    @(posedge clock);
    #1;
    check("rf_we", rf_we, exp_we);
    if (exp_we) begin
      check("rf_rd_id", rf_rd_id, exp_rd);
      check("rf_data", rf_data, exp_data);
    end
    check("overflow", overflow, exp_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic          mv, av;
    logic [RW-1:0] qid;
    exp_we = 1'b0; exp_ovf = 1'b0; exp_rd = '0; exp_data = '0;

    // Reset values
    #2;
    check("reset rf_we", rf_we, 1'b0);
    check("reset rf_rd_id", rf_rd_id, '0);
    check("reset rf_data", rf_data, '0);
    check("reset overflow", overflow, 1'b0);
    check("reset wb_stall", wb_stall, 1'b0);
    check("reset hdu_query_hit", hdu_query_hit, 1'b0);
    @(negedge clock); reset = 1'b1;

    // Bypass into empty FIFO
    step(1'b0, '0, '0, 1'b1, 5'd3, 32'h11, 5'd3);
    idle(1);

    // Collision: mul wins, ALU result follows one cycle later
    step(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB, 5'd6);
    step(1'b0, '0, '0, 1'b0, '0, '0, 5'd6);
    idle(1);

    // Order under pressure, querying queued ids while mul holds the port
    step(1'b1, 5'd20, 32'h100, 1'b1, 5'd1, 32'h1, 5'd1);
    step(1'b1, 5'd21, 32'h101, 1'b1, 5'd2, 32'h2, 5'd1);
    step(1'b1, 5'd22, 32'h102, 1'b1, 5'd3, 32'h3, 5'd2);
    step(1'b0, '0, '0, 1'b1, 5'd4, 32'h4, 5'd3);
    idle(4);

    // Wrap-around with alternating mul/ALU traffic
    for (int i = 0; i < 10; i++)
      step(i % 2 == 0, 5'(i + 8), $urandom, 1'b1, 5'(i), $urandom, 5'(i));
    idle(3);

    // Overflow: five pushes under a continuous mul burst
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'd31, $urandom, 1'b1, 5'(i + 10), 32'hC0 + 32'(i), 5'd14);
    idle(6);

    // Reset mid-operation
    step(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd8);
    step(1'b1, 5'd7, 32'h78, 1'b1, 5'd9, 32'h99, 5'd9);
    @(negedge clock);
    mul_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset rf_we", rf_we, 1'b0);
    check("midreset rf_rd_id", rf_rd_id, '0);
    check("midreset rf_data", rf_data, '0);
    check("midreset overflow", overflow, 1'b0);
    check("midreset wb_stall", wb_stall, 1'b0);
    exp_q.delete(); exp_ovf = 1'b0; exp_we = 1'b0;
    @(negedge clock); reset = 1'b1;
    idle(4);

    // Random traffic; upstream occasionally ignores stall
    for (int i = 0; i < 400; i++) begin
      mv  = ($urandom_range(0, 2) == 0);
      av  = (exp_q.size() >= DEPTH - 1) ? ($urandom_range(0, 9) == 0) : $urandom_range(0, 1) == 1;
      qid = 5'($urandom_range(0, 7));
      step(mv, 5'($urandom_range(0, 31)), $urandom, av, 5'($urandom_range(0, 7)), $urandom, qid);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
